// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

   // Which source feeds the PC register on the next edge.
   typedef enum logic [2:0] {
      SEL_HOLD,
      SEL_SEQ,
      SEL_BR,
      SEL_J,
      SEL_JR,
      SEL_ERET,
      SEL_EXC
   } pc_sel_t;

   typedef enum logic {
      RUN,
      HANDLER
   } pc_state_t;

   localparam int unsigned PC_WIDTH_DEF     = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_0080;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidates: pc+4, branch, jump and jump-register
// targets, plus misalignment flags for the targets that can be misaligned.
module pc_next_calc
   import pc_pkg::*;
#(
   parameter int unsigned WIDTH = PC_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] pc,
   input  logic [15:0]      br_offset,
   input  logic [WIDTH-7:0] j_target,
   input  logic [WIDTH-1:0] jr_addr,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] br_target,
   output logic [WIDTH-1:0] j_addr,
   output logic [WIDTH-1:0] jr_target,
   output logic             br_misal,
   output logic             jr_misal
);

   logic signed [17:0] br_byte_off;
   logic [WIDTH-1:0]   br_ext;

   // Target arithmetic wraps modulo 2^WIDTH; the word offset is scaled to
   // bytes before sign extension so the cast carries the sign correctly.
   always_comb begin
      br_byte_off = {br_offset, 2'b00};
      br_ext      = WIDTH'(br_byte_off);
      pc_plus4    = pc + WIDTH'(4);
      br_target   = pc_plus4 + br_ext;
      j_addr      = {pc_plus4[WIDTH-1:WIDTH-4], j_target, 2'b00};
      jr_target   = jr_addr;
      br_misal    = |br_target[1:0];
      jr_misal    = |jr_target[1:0];
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, picks the next PC by fixed priority,
// and tracks exception entry/return with an EPC register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal fetch; an exception saves pc to epc and enters HANDLER
// HANDLER | in exception handler; eret restores epc, a new exception
//         | re-enters the handler and sets the sticky double_fault flag
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     WIDTH        = PC_WIDTH_DEF,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      br_offset,
   input  logic             jump,
   input  logic [WIDTH-7:0] j_target,
   input  logic             jr,
   input  logic [WIDTH-1:0] jr_addr,
   input  logic             exc,
   input  logic             eret,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] pc_plus4,
   output logic [WIDTH-1:0] epc,
   output logic             in_handler,
   output logic             addr_err,
   output logic             double_fault
);

   pc_state_t        state;
   pc_sel_t          sel;
   logic             misal_trap;
   logic [WIDTH-1:0] br_target;
   logic [WIDTH-1:0] j_addr;
   logic [WIDTH-1:0] jr_target;
   logic             br_misal;
   logic             jr_misal;

   pc_next_calc #(
      .WIDTH (WIDTH)
   ) u_next_calc (
      .pc        (pc),
      .br_offset (br_offset),
      .j_target  (j_target),
      .jr_addr   (jr_addr),
      .pc_plus4  (pc_plus4),
      .br_target (br_target),
      .j_addr    (j_addr),
      .jr_target (jr_target),
      .br_misal  (br_misal),
      .jr_misal  (jr_misal)
   );

   assign in_handler = (state == HANDLER);

   // Strict priority select; a misaligned jr/branch target becomes an exception.
   // eret outside the handler is a plain sequential step that still masks
   // the lower-priority requests.
   always_comb begin
      sel        = SEL_SEQ;
      misal_trap = 1'b0;
      if (stall) begin
         sel = SEL_HOLD;
      end else if (exc) begin
         sel = SEL_EXC;
      end else if (eret) begin
         sel = (state == HANDLER) ? SEL_ERET : SEL_SEQ;
      end else if (jr) begin
         if (jr_misal) begin
            sel        = SEL_EXC;
            misal_trap = 1'b1;
         end else begin
            sel = SEL_JR;
         end
      end else if (jump) begin
         sel = SEL_J;
      end else if (branch_taken) begin
         if (br_misal) begin
            sel        = SEL_EXC;
            misal_trap = 1'b1;
         end else begin
            sel = SEL_BR;
         end
      end
   end

   // PC/EPC registers, exception FSM and fault flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc           <= RESET_VECTOR;
         epc          <= '0;
         state        <= RUN;
         addr_err     <= 1'b0;
         double_fault <= 1'b0;
      end else begin
         addr_err <= misal_trap;
         case (sel)
            SEL_HOLD: ;
            SEL_SEQ:  pc <= pc_plus4;
            SEL_BR:   pc <= br_target;
            SEL_J:    pc <= j_addr;
            SEL_JR:   pc <= jr_target;
            SEL_ERET: begin
               pc    <= epc;
               state <= RUN;
            end
            SEL_EXC: begin
               pc <= EXC_VECTOR;
               if (state == RUN) begin
                  epc   <= pc;
                  state <= HANDLER;
               end else begin
                  double_fault <= 1'b1;
               end
            end
            default:  pc <= pc_plus4;
         endcase
      end
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit that replaces the bare PC register in the single-cycle MIPS datapath. It holds the PC and computes the next PC internally from decoded control: sequential, branch, jump, jump-register, exception entry and exception return. It also supports stalls, captures an exception return address (EPC), and detects misaligned targets. It sits between the control/ALU outputs and the instruction memory address port.

## Interface
Parameters:
- WIDTH, 32, address width; ≥16, multiple of 4
- RESET_VECTOR, 0, PC value after reset; bits [1:0] must be 0
- EXC_VECTOR, 32'h80, exception handler entry; bits [1:0] must be 0

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold all state this cycle
- branch_taken  in  1  take PC-relative branch
- br_offset  in  16  signed word offset
- jump  in  1  pseudo-direct jump
- j_target  in  WIDTH-6  jump index field
- jr  in  1  jump to register
- jr_addr  in  WIDTH  register target
- exc  in  1  synchronous exception request
- eret  in  1  return from handler
- pc  out  WIDTH  current PC, registered
- pc_plus4  out  WIDTH  pc+4, combinational
- epc  out  WIDTH  saved return address, registered
- in_handler  out  1  FSM in HANDLER state
- addr_err  out  1  one-cycle pulse, misaligned target trapped
- double_fault  out  1  sticky fault flag

## Operation
- Reset (reset=0, asynchronous) sets the following: pc=RESET_VECTOR, epc=0, state=RUN, addr_err=0, double_fault=0.
- Arithmetic is modulo 2^WIDTH; there is no overflow detection.
  - Sequential target: pc+4.
  - Branch target: pc+4 + (sign_extend(br_offset) << 2).
  - Jump target: {pc_plus4[WIDTH-1:WIDTH-4], j_target, 2'b00}.
  - Jump-register target: jr_addr.
- Priority per cycle, highest first: stall, exc, eret, jr, jump, branch_taken, sequential.
- stall=1 changes no state, and addr_err is 0. exc is dropped while stall=1, so upstream holds exc until the stall clears.
- Alignment check applies to the selected jr or branch target only. If target[1:0]≠0, the cycle is treated as an exception and addr_err=1 for the next cycle.
- FSM states:
  - RUN, exception (exc or misalignment):
    - pc←EXC_VECTOR
    - epc←pc
    - go to HANDLER.
  - HANDLER, eret:
    - pc←epc
    - go to RUN.
  - HANDLER, exception:
    - pc←EXC_VECTOR
    - epc unchanged
    - double_fault←1
    - stay in HANDLER.
  - RUN, eret: no-op, treated as sequential.
  - Otherwise the selected target is loaded and the state is unchanged.
- double_fault is cleared only by reset.

## Timing
- All registered outputs update on the rising clk edge. pc_plus4 follows pc combinationally.
- Next-PC latency is 1 cycle: controls sampled at edge N take effect on pc after edge N.
- addr_err is high for exactly the cycle after the trapping edge.
- Reset asserted mid-operation forces the reset values immediately, without waiting for clk. Deassertion is synchronised externally.
- Simultaneous requests resolve strictly by the priority order above; lower-priority requests in the same cycle are discarded.

## Structure
- Package pc_pkg contains:
  - next-PC select enum {SEL_HOLD, SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_ERET, SEL_EXC}
  - state enum {RUN, HANDLER}
  - default vector constants.
- Sub-module pc_next_calc is combinational. It computes pc_plus4 and the branch, jump and jr targets, plus the misalignment flag.
- pc_unit holds the priority select, FSM, pc, epc and flag registers.

## Test plan
- Reset → sequential fetch: reset low, then high; 3 idle cycles → pc=0, 4, 8, 12.
- Branch and jump:
  - At pc=0x10, branch_taken with br_offset=-2 → pc=0xC.
  - At pc=0x00400000, jump with j_target=0x40 → pc=0x00000100.
- Stall vs. exception: at pc=0x20, stall=1 and exc=1 for 2 cycles → pc stays 0x20. Then stall=0 with exc=1 → pc=0x80, epc=0x20, in_handler=1. Then eret → pc=0x20, in_handler=0.
- Misaligned jr: jr_addr=0x102 at pc=0x40 → pc=0x80, epc=0x40, addr_err=1 for exactly one cycle.
- Double fault: in HANDLER with epc=0x40, exc=1 → pc=0x80, epc still 0x40, double_fault=1. double_fault stays set after eret until reset.
- Priority and async reset:
  - exc+eret+jr+jump in one cycle → exception path taken.
  - reset pulsed low between clk edges mid-handler → pc=RESET_VECTOR, in_handler=0 before the next edge.
